// File: rtl/pool2_stream_reader_pkg.sv
// Shared layer constants for the CNN result-BRAM readers and a word-address helper.
`default_nettype none

package pool2_stream_reader_pkg;

  localparam int DATA_SIZE              = 16;
  localparam int CONV2_DEEP             = 16;
  localparam int POOL2_OUTPUT           = 5;
  localparam int BRAM_ADDR_W            = 13;
  localparam int POOL1_RESULT_BASE_ADDR = 5880;
  localparam int POOL2_RESULT_BASE_ADDR = 7480;
  localparam int POOL2_WORDS            = CONV2_DEEP * POOL2_OUTPUT * POOL2_OUTPUT;

  // Channel-major flattened word address, truncated to the BRAM address width.
  function automatic logic [BRAM_ADDR_W-1:0] word_addr(input int base, input logic [8:0] idx);
    return BRAM_ADDR_W'(base + int'(idx));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool2_stream_reader.sv
// Streams the pool2 feature map out of the result BRAM, one outstanding read at a time,
// onto a valid/ready interface feeding the FC layer.
`default_nettype none

module pool2_stream_reader
  import pool2_stream_reader_pkg::*;
#(
  parameter int POOL2_RESULT_BASE = POOL2_RESULT_BASE_ADDR,
  parameter int WORD_COUNT        = POOL2_WORDS,
  parameter int READ_LATENCY      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stream_en,
  input  logic [DATA_SIZE-1:0]   result_bram_douta,
  output logic                   result_bram_ena,
  output logic                   result_bram_wea,
  output logic [BRAM_ADDR_W-1:0] result_bram_addra,
  output logic [DATA_SIZE-1:0]   m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   stream_finish
);

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_ISSUE = 5'b00010;
  localparam logic [4:0] S_WAIT  = 5'b00100;
  localparam logic [4:0] S_OUT   = 5'b01000;
  localparam logic [4:0] S_DONE  = 5'b10000;

  localparam int              WAIT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
  localparam logic [8:0]      LAST_IDX  = 9'(WORD_COUNT - 1);

  logic [4:0]             state_q,  state_d;
  logic [8:0]             idx_q,    idx_d;
  logic [WAIT_W-1:0]      wait_q,   wait_d;
  logic                   ena_q,    ena_d;
  logic [BRAM_ADDR_W-1:0] addra_q,  addra_d;
  logic [DATA_SIZE-1:0]   data_q,   data_d;
  logic                   valid_q,  valid_d;
  logic                   last_q,   last_d;
  logic                   finish_q, finish_d;
  logic                   frozen;

  // A dropped enable stalls everything except the final handshake back to idle.
  assign frozen = !stream_en && (state_q != S_DONE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    ena_d    = ena_q;
    addra_d  = addra_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    finish_d = finish_q;
    if (!frozen) begin
      case (state_q)
        S_IDLE: begin
          idx_d    = '0;
          wait_d   = '0;
          finish_d = 1'b0;
          state_d  = S_ISSUE;
        end
        S_ISSUE: begin
          ena_d   = 1'b1;
          addra_d = word_addr(POOL2_RESULT_BASE, idx_q);
          wait_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) begin
            data_d  = result_bram_douta;
            ena_d   = 1'b0;
            valid_d = 1'b1;
            last_d  = (idx_q == LAST_IDX);
            state_d = S_OUT;
          end
        end
        S_OUT: begin
          if (valid_q && m_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = idx_q + 9'd1;
            if (idx_q == LAST_IDX) begin
              finish_d = 1'b1;
              state_d  = S_DONE;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_DONE: begin
          ena_d    = 1'b0;
          finish_d = 1'b1;
          if (!stream_en) begin
            finish_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
        default: begin
          ena_d   = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wait_q   <= '0;
      ena_q    <= 1'b0;
      addra_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      ena_q    <= ena_d;
      addra_q  <= addra_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      finish_q <= finish_d;
    end
  end

  assign result_bram_ena   = ena_q;
  assign result_bram_wea   = 1'b0;
  assign result_bram_addra = addra_q;
  assign m_data            = data_q;
  assign m_valid           = valid_q;
  assign m_last            = last_q;
  assign stream_finish     = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_pool2_stream_reader.sv
// Bench for pool2_stream_reader: BRAM model, expected-word model and per-cycle compare.
`default_nettype none

module tb_pool2_stream_reader;

  localparam int BASE = 7480;
  localparam int WC   = 400;
  localparam int LAT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stream_en = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] douta;
  logic        ena, wea, m_valid, m_last, stream_finish;
  logic [12:0] addra;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  pool2_stream_reader #(
    .POOL2_RESULT_BASE (BASE),
    .WORD_COUNT        (WC),
    .READ_LATENCY      (LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stream_en         (stream_en),
    .result_bram_douta (douta),
    .result_bram_ena   (ena),
    .result_bram_wea   (wea),
    .result_bram_addra (addra),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_last            (m_last),
    .stream_finish     (stream_finish)
  );

  // BRAM: address captured while enabled, data emerges READ_LATENCY edges later.
  logic [15:0] mem  [0:8191];
  logic [15:0] pipe [0:LAT-2];
  always @(posedge clk) begin
    if (ena) pipe[0] <= mem[addra];
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign douta = pipe[LAT-2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ena"},    32'(ena),           32'd0);
    chk({tag, "_wea"},    32'(wea),           32'd0);
    chk({tag, "_addra"},  32'(addra),         32'd0);
    chk({tag, "_data"},   32'(m_data),        32'd0);
    chk({tag, "_valid"},  32'(m_valid),       32'd0);
    chk({tag, "_last"},   32'(m_last),        32'd0);
    chk({tag, "_finish"}, 32'(stream_finish), 32'd0);
  endtask

  // Model state: k = words accepted so far, rd_cnt = reads issued so far.
  int          k = 0;
  int          rd_cnt = 0;
  bit          mon_on = 1'b0;
  logic        en_prev = 1'b1;
  logic        hold_pend = 1'b0;
  logic        prev_ena = 1'b0;
  logic [12:0] prev_addra = '0;
  logic        prev_valid = 1'b0;
  logic        prev_last = 1'b0;
  logic [15:0] prev_data = '0;
  logic [15:0] first_w = '0;
  logic [15:0] last_w = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst || !mon_on) begin
        k = 0; rd_cnt = 0; en_prev = 1'b1; hold_pend = 1'b0; prev_ena = 1'b0;
      end else begin
        chk("wea_zero", 32'(wea), 32'd0);
        if (!en_prev) begin
          chk("frz_ena",   32'(ena),     32'(prev_ena));
          chk("frz_addra", 32'(addra),   32'(prev_addra));
          chk("frz_valid", 32'(m_valid), 32'(prev_valid));
          chk("frz_data",  32'(m_data),  32'(prev_data));
          chk("frz_last",  32'(m_last),  32'(prev_last));
        end
        if (hold_pend) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data",  32'(m_data),  32'(prev_data));
          chk("hold_last",  32'(m_last),  32'(prev_last));
        end
        if (m_valid) begin
          if (k < WC) begin
            chk("data", 32'(m_data), 32'(mem[BASE+k]));
            chk("last", 32'(m_last), 32'(k == WC - 1));
          end else begin
            chk("extra_word", 32'(k), 32'(WC - 1));
          end
          if (m_ready && stream_en) begin
            if (k == 0) first_w = m_data;
            if (k == WC - 1) last_w = m_data;
            k++;
          end
        end
        if (ena && !prev_ena) begin
          chk("addr_seq",   32'(addra), 32'(BASE + rd_cnt));
          chk("addr_range", 32'(addra >= 13'(BASE) && addra <= 13'(BASE + WC - 1)), 32'd1);
          rd_cnt++;
        end
        if (stream_finish) chk("finish_count", 32'(k), 32'(WC));
        en_prev    = stream_en;
        hold_pend  = m_valid && !(m_ready && stream_en);
        prev_ena   = ena;
        prev_addra = addra;
        prev_valid = m_valid;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  // m_ready: 0 = always high, 1 = ~30% high, 2 = held low.
  int rmode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 9) < 3);
        default: m_ready = 1'b0;
      endcase
    end
  end

  task automatic wait_finish(input string tag, input int budget, output int n);
    n = 0;
    while (!stream_finish && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_finish"}, 32'(stream_finish), 32'd1);
  endtask

  task automatic end_run(input string tag);
    stream_en = 1'b0;
    @(posedge clk);
    #2;
    chk({tag, "_finish_clr"}, 32'(stream_finish), 32'd0);
    @(posedge clk);
    #2;
    k = 0;
    rd_cnt = 0;
  endtask

  int n;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    for (int i = 0; i < WC; i++) mem[BASE+i] = 16'(i * 3);

    repeat (3) @(posedge clk);
    #2;
    chk_reset("reset");
    rst = 1'b0;
    mon_on = 1'b1;

    // Full-rate stream: one idle cycle then five cycles per word.
    rmode = 0;
    @(posedge clk);
    #2;
    stream_en = 1'b1;
    wait_finish("runA", 5000, n);
    chk("runA_cycles", 32'(n), 32'd2001);
    chk("runA_words", 32'(k), 32'd400);
    chk("runA_first", 32'(first_w), 32'd0);
    chk("runA_lastw", 32'(last_w), 32'd1197);
    end_run("runA");

    // Extreme values, throttled ready, enable dropped in the read of word 57.
    mem[BASE]        = 16'h8001;
    mem[BASE+WC-1]   = 16'h7FFF;
    rmode = 1;
    stream_en = 1'b1;
    n = 0;
    while (!(ena && addra == 13'(BASE + 57)) && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("runB_reach57", 32'(addra), 32'(BASE + 57));
    stream_en = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    stream_en = 1'b1;
    wait_finish("runB", 20000, n);
    chk("runB_words", 32'(k), 32'd400);
    chk("runB_first", 32'(first_w), 32'h8001);
    chk("runB_lastw", 32'(last_w), 32'h7FFF);
    end_run("runB");

    // Reset while word 200 waits in the output register, then a clean restart.
    rmode = 1;
    stream_en = 1'b1;
    n = 0;
    while (k < 200 && n < 20000) begin
      @(posedge clk);
      #2;
      n++;
    end
    rmode = 2;
    n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("runC_hold200", 32'(m_valid), 32'd1);
    chk("runC_k200", 32'(k), 32'd200);
    rst = 1'b1;
    #1;
    chk_reset("midreset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    rmode = 1;
    wait_finish("runC", 20000, n);
    chk("runC_words", 32'(k), 32'd400);
    chk("runC_first", 32'(first_w), 32'h8001);
    chk("runC_lastw", 32'(last_w), 32'h7FFF);
    end_run("runC");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pool2_stream_reader.md
POOL2_STREAM_READER -- requirements
Module: pool2_stream_reader

Interface
REQ-001 Parameter POOL2_RESULT_BASE, default 7480: result-BRAM word address of the first pool2 output.
REQ-002 Parameter WORD_COUNT, default 400: pool2 outputs to stream (16 channels x 5 x 5).
REQ-003 Parameter READ_LATENCY, default 3: cycles from the address/ena cycle to the cycle douta is sampled.
REQ-004 Port clk, in, 1: single clock; all logic on posedge.
REQ-005 Port rst, in, 1: reset, asynchronous, active-high.
REQ-006 Port stream_en, in, 1: layer enable; high = run, low = freeze.
REQ-007 Port result_bram_douta, in, 16: BRAM read data.
REQ-008 Port result_bram_ena, out, 1: BRAM enable.
REQ-009 Port result_bram_wea, out, 1: BRAM write enable; constant 0.
REQ-010 Port result_bram_addra, out, 13: BRAM address.
REQ-011 Port m_data, out, 16: streamed pool2 word (signed Q-format, passed unchanged).
REQ-012 Port m_valid, out, 1: m_data valid.
REQ-013 Port m_ready, in, 1: downstream FC layer accepts the word.
REQ-014 Port m_last, out, 1: high with the final word (index WORD_COUNT-1).
REQ-015 Port stream_finish, out, 1: all words accepted.

Function
REQ-016 States: S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_DONE, one-hot; unused encodings go to S_IDLE with ena low.
REQ-017 Words are read in flattened channel-major order: word i is at POOL2_RESULT_BASE + i, for i = 0..WORD_COUNT-1 (ch*25 + row*5 + col).
REQ-018 S_IDLE with stream_en=1: clear index and wait counter, clear stream_finish, go to S_ISSUE.
REQ-019 S_ISSUE: drive ena=1, addra = base + index, clear the wait counter, go to S_WAIT.
REQ-020 S_WAIT: increment the wait counter; when it reaches READ_LATENCY-1, register douta into m_data, drop ena, set m_valid, set m_last iff index == WORD_COUNT-1, go to S_OUT.
REQ-021 S_OUT: hold m_data/m_valid/m_last stable until m_valid && m_ready; on handshake clear m_valid/m_last, increment index, and go to S_DONE if the index was WORD_COUNT-1, else to S_ISSUE.
REQ-022 Exactly one read is outstanding at a time; minimum period is READ_LATENCY+2 cycles per word.
REQ-023 S_DONE: ena=0, stream_finish=1, held while stream_en=1; when stream_en=0, go to S_IDLE and clear stream_finish.
REQ-024 stream_en=0 in any state other than S_DONE freezes all state and outputs; the BRAM read in flight completes because douta is sampled only while enabled, and ena stays at its frozen value.
REQ-025 m_ready high while m_valid is low has no effect; m_ready is never combinationally fed to any output.
REQ-026 The index counter is 9 bits, and the address sum is truncated to 13 bits; WORD_COUNT=400 never wraps.

Reset
REQ-027 Asynchronous rst=1 forces S_IDLE; ena=0, wea=0, addra=0, m_data=0, m_valid=0, m_last=0, stream_finish=0, index=0, wait counter=0.
REQ-028 rst asserted mid-stream aborts without a finish pulse; after release, a fresh stream restarts at word 0.

Structure
REQ-029 The shared layer package holds DATA_SIZE=16, CONV2_DEEP=16, POOL2_OUTPUT=5, the BRAM address width 13, and the base addresses 5880 and 7480.
REQ-030 The design is a single module with no sub-module; a BRAM model is used only in the bench.

Verification
REQ-031 Preload BRAM[7480+i] = i*3; stream_en=1 with m_ready=1 throughout -> 400 words equal to i*3 in order, m_last only on word 399, then stream_finish=1.
REQ-032 m_ready toggled pseudo-randomly with 30% high -> same 400-word sequence; m_data/m_last stable while m_valid && !m_ready.
REQ-033 stream_en dropped for 7 cycles during S_WAIT of word 57 -> no word lost or duplicated, and ena/addra are held.
REQ-034 rst pulsed while word 200 is in S_OUT -> all outputs 0 immediately (asynchronous); a restarted stream begins at address 7480.
REQ-035 Negative data 16'h8001 at word 0 and 16'h7FFF at word 399 -> passed bit-exact; wea stays 0 for the entire run.
REQ-036 Address monitor checks addra ranges only over 7480..7879, strictly increasing by 1 per read.
